// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared single-port instruction/data RAM: MEM-stage accesses win
// over fetches, each access is sequenced over MEM_LAT cycles, and the pipeline stall vector is driven.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int MEM_LAT = 2  // legal range 1..7 (cnt is 3 bits)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        flush,
    output logic [5:0]  stall,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM,
        DONE_IF,
        DONE_MEM
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [2:0] LAST_CNT   = 3'(MEM_LAT - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       kill;
    logic       post_rst;
    logic       last;

    assign last = (cnt == LAST_CNT);

    // The cycle after reset neither grants nor stalls, so the pipeline restarts cleanly.
    always_comb begin
        // NOTE: default assigned first so every path drives stall and no latch is inferred.
        stall = STALL_NONE;
        if (!rst && !post_rst) begin
            case (state)
                IDLE: begin
                    if (mem_req)
                        stall = STALL_MEM;
                    else if (if_req && !flush)
                        stall = STALL_IF;
                end
                BUSY_MEM: stall = STALL_MEM;
                BUSY_IF:  if (!flush) stall = STALL_IF;
                DONE_MEM: if (if_req) stall = STALL_IF;
                default:  stall = STALL_NONE;
            endcase
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            kill      <= 1'b0;
            post_rst  <= 1'b1;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_sel   <= 4'h0;
            ram_addr  <= 32'h0;
            ram_wdata <= 32'h0;
            if_inst   <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            post_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (!post_rst && mem_req) begin
                        state     <= BUSY_MEM;
                        cnt       <= 3'd0;
                        ram_ce    <= 1'b1;
                        ram_we    <= mem_we;
                        ram_sel   <= mem_sel;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                    end else if (!post_rst && if_req) begin
                        state     <= BUSY_IF;
                        cnt       <= 3'd0;
                        kill      <= flush;
                        ram_ce    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_sel   <= 4'hF;
                        ram_addr  <= if_addr;
                        ram_wdata <= 32'h0;
                    end
                end

                BUSY_IF: begin
                    cnt <= cnt + 3'd1;
                    if (flush)
                        kill <= 1'b1;
                    if (last) begin
                        ram_ce <= 1'b0;
                        ram_we <= 1'b0;
                        // A flushed fetch drains silently: no capture, no DONE_IF.
                        if (kill || flush) begin
                            state <= IDLE;
                            kill  <= 1'b0;
                        end else begin
                            if_inst <= ram_rdata;
                            state   <= DONE_IF;
                        end
                    end
                end

                BUSY_MEM: begin
                    cnt <= cnt + 3'd1;
                    if (last) begin
                        ram_ce <= 1'b0;
                        ram_we <= 1'b0;
                        if (!ram_we)
                            mem_rdata <= ram_rdata;
                        state <= DONE_MEM;
                    end
                end

                DONE_IF:  state <= IDLE;
                DONE_MEM: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter at MEM_LAT = 2, 1 and 4, with a
// transaction-level RAM model and per-cycle stall expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] S_IF  = 6'b000011;
    localparam logic [5:0] S_MEM = 6'b011111;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          killed;
    } txn_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_init(input logic [29:0] w);
        return ({w, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;

        logic        rst, if_req, mem_req, mem_we, flush, ram_ce, ram_we;
        logic [31:0] if_addr, if_inst, mem_addr, mem_wdata, mem_rdata;
        logic [31:0] ram_addr, ram_wdata, ram_rdata;
        logic [3:0]  mem_sel, ram_sel;
        logic [5:0]  stall;

        txn_t        txn_q[$];
        logic [5:0]  stall_q[$];
        logic [31:0] hw_mem[logic [29:0]];
        logic [31:0] model_mem[logic [29:0]];
        int          hw_cnt;

        txn_t        cur;
        logic        prev_ce, prev_rst;
        bit          in_flight;
        int          ce_len;
        logic [31:0] exp_if, exp_mem;

        mem_port_arbiter #(.MEM_LAT(L)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_inst  (if_inst),
            .mem_req  (mem_req),
            .mem_we   (mem_we),
            .mem_sel  (mem_sel),
            .mem_addr (mem_addr),
            .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata),
            .flush    (flush),
            .stall    (stall),
            .ram_ce   (ram_ce),
            .ram_we   (ram_we),
            .ram_sel  (ram_sel),
            .ram_addr (ram_addr),
            .ram_wdata(ram_wdata),
            .ram_rdata(ram_rdata)
        );

        task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
            check($sformatf("lat%0d.%s", L, name), act, exp);
        endtask

        function automatic logic [31:0] hw_read(input logic [29:0] w);
            return hw_mem.exists(w) ? hw_mem[w] : ram_init(w);
        endfunction

        function automatic logic [31:0] model_read(input logic [29:0] w);
            return model_mem.exists(w) ? model_mem[w] : ram_init(w);
        endfunction

        // RAM: data valid only in the last enabled cycle; writes commit in that cycle.
        initial begin
            ram_rdata = 32'h0;
            hw_cnt    = 0;
            forever begin
                @(negedge clk);
                if (ram_ce === 1'b1) begin
                    if (hw_cnt == L - 1) begin
                        ram_rdata = hw_read(ram_addr[31:2]);
                        if (ram_we === 1'b1)
                            hw_mem[ram_addr[31:2]] = merge(ram_rdata, ram_wdata, ram_sel);
                    end else begin
                        ram_rdata = 32'hBAD00000 | 32'(hw_cnt);
                    end
                    hw_cnt++;
                end else begin
                    hw_cnt    = 0;
                    ram_rdata = 32'hBAD0FFFF;
                end
            end
        end

        // Monitor: per-cycle stall, plus per-access RAM fields and captured data.
        initial begin
            prev_ce   = 1'b0;
            prev_rst  = 1'b0;
            in_flight = 0;
            ce_len    = 0;
            exp_if    = 32'h0;
            exp_mem   = 32'h0;
            forever begin
                @(negedge clk);
                if (stall_q.size() > 0)
                    chk("stall", 32'(stall), 32'(stall_q.pop_front()));
                if (prev_rst === 1'b1) begin
                    chk("rst_ram_ce", 32'(ram_ce), 32'h0);
                    chk("rst_ram_we", 32'(ram_we), 32'h0);
                    chk("rst_ram_addr", ram_addr, 32'h0);
                    chk("rst_if_inst", if_inst, 32'h0);
                    chk("rst_mem_rdata", mem_rdata, 32'h0);
                    exp_if  = 32'h0;
                    exp_mem = 32'h0;
                end
                if (ram_ce === 1'b1 && prev_ce !== 1'b1) begin
                    chk("txn_pending", 32'(txn_q.size() != 0), 32'h1);
                    if (txn_q.size() != 0) begin
                        cur       = txn_q.pop_front();
                        in_flight = 1;
                        ce_len    = 1;
                        chk("ram_addr", ram_addr, cur.addr);
                        chk("ram_we", 32'(ram_we), 32'(cur.we));
                        chk("ram_sel", 32'(ram_sel), 32'(cur.sel));
                        if (cur.we)
                            chk("ram_wdata", ram_wdata, cur.wdata);
                    end
                end else if (ram_ce === 1'b1 && in_flight) begin
                    ce_len++;
                    chk("ram_addr_hold", ram_addr, cur.addr);
                    chk("ram_we_hold", 32'(ram_we), 32'(cur.we));
                end else if (ram_ce !== 1'b1 && prev_ce === 1'b1 && in_flight) begin
                    chk("ce_cycles", ce_len, L);
                    if (!cur.is_mem && !cur.killed) exp_if = cur.rdata;
                    if (cur.is_mem && !cur.we)      exp_mem = cur.rdata;
                    chk("if_inst", if_inst, exp_if);
                    chk("mem_rdata", mem_rdata, exp_mem);
                    in_flight = 0;
                end
                if (rst === 1'b1) in_flight = 0;
                prev_ce  = ram_ce;
                prev_rst = rst;
            end
        end

        task automatic drive(input logic [5:0] exp);
            stall_q.push_back(exp);
            @(posedge clk);
            #1;
        endtask

        task automatic op_idle(input int n);
            for (int i = 0; i < n; i++) begin
                if_req  = 1'b0;
                mem_req = 1'b0;
                mem_we  = 1'b0;
                flush   = 1'($urandom_range(0, 1));
                drive(6'b0);
            end
            flush = 1'b0;
        endtask

        // flush_at < 0: normal fetch; otherwise flush pulses in cycle flush_at (0 = grant cycle).
        task automatic op_fetch(input logic [31:0] addr, input int flush_at);
            txn_t t;
            t.is_mem = 0;
            t.we     = 0;
            t.sel    = 4'hF;
            t.addr   = addr;
            t.wdata  = 32'h0;
            t.rdata  = model_read(addr[31:2]);
            t.killed = (flush_at >= 0);
            txn_q.push_back(t);
            mem_req = 1'b0;
            mem_we  = 1'b0;
            if_req  = 1'b1;
            if_addr = addr;
            for (int k = 0; k <= L; k++) begin
                flush = (k == flush_at);
                if (flush_at >= 0 && k > flush_at)
                    if_addr = $urandom;
                drive((k == flush_at) ? 6'b0 : S_IF);
            end
            if (flush_at < 0) begin
                flush = 1'($urandom_range(0, 1));
                drive(6'b0);
            end
            flush = 1'b0;
        endtask

        task automatic op_mem(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit with_if,
                              input logic [31:0] if_a);
            txn_t t;
            t.is_mem = 1;
            t.we     = we;
            t.sel    = sel;
            t.addr   = addr;
            t.wdata  = wdata;
            t.rdata  = model_read(addr[31:2]);
            t.killed = 0;
            if (we)
                model_mem[addr[31:2]] = merge(t.rdata, wdata, sel);
            txn_q.push_back(t);
            mem_req   = 1'b1;
            mem_we    = we;
            mem_sel   = sel;
            mem_addr  = addr;
            mem_wdata = wdata;
            if_req    = with_if;
            if_addr   = if_a;
            for (int k = 0; k <= L; k++) begin
                flush = 1'($urandom_range(0, 1));
                drive(S_MEM);
            end
            flush = 1'($urandom_range(0, 1));
            drive(with_if ? S_IF : 6'b0);
            mem_req = 1'b0;
            mem_we  = 1'b0;
            flush   = 1'b0;
            if (with_if)
                op_fetch(if_a, -1);
        endtask

        // Reset lands at cnt==2 for MEM_LAT=4, or on the capture cycle for shorter latencies.
        task automatic op_reset_mem(input logic [31:0] addr);
            txn_t t;
            int   kr;
            kr       = (L < 3) ? L : 3;
            t.is_mem = 1;
            t.we     = 0;
            t.sel    = 4'hF;
            t.addr   = addr;
            t.wdata  = 32'h0;
            t.rdata  = model_read(addr[31:2]);
            t.killed = 0;
            txn_q.push_back(t);
            mem_req  = 1'b1;
            mem_we   = 1'b0;
            mem_sel  = 4'hF;
            mem_addr = addr;
            if_req   = 1'b0;
            flush    = 1'b0;
            for (int k = 0; k < kr; k++)
                drive(S_MEM);
            rst    = 1'b1;
            if_req = 1'b1;
            drive(6'b0);
            rst     = 1'b0;
            mem_req = 1'b0;
            if_req  = 1'b0;
            drive(6'b0);
        endtask

        initial begin
            rst       = 1'b1;
            if_req    = 1'b0;
            if_addr   = 32'h0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_sel   = 4'h0;
            mem_addr  = 32'h0;
            mem_wdata = 32'h0;
            flush     = 1'b0;
            hw_mem[30'h40]    = 32'h24080005;
            model_mem[30'h40] = 32'h24080005;
            hw_mem[30'h80]    = 32'hDEADBEEF;
            model_mem[30'h80] = 32'hDEADBEEF;
            @(posedge clk);
            #1;
            drive(6'b0);
            drive(6'b0);
            rst = 1'b0;
            drive(6'b0);

            op_fetch(32'h100, -1);
            op_fetch(rand_addr(), -1);
            op_mem(1'b0, 4'hF, 32'h200, 32'h0, 1'b1, 32'h104);
            op_mem(1'b1, 4'b0011, 32'h40, 32'h1234, 1'b0, 32'h0);
            op_mem(1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 32'h0);
            op_idle(2);
            op_fetch(32'h300, 1);
            op_fetch(32'h100, -1);
            op_reset_mem(32'h200);
            op_idle(1);

            repeat (40) begin
                case ($urandom_range(0, 5))
                    0: op_idle($urandom_range(1, 3));
                    1: op_fetch(rand_addr(), -1);
                    2: begin
                        op_fetch(rand_addr(), $urandom_range(0, L));
                        op_fetch(rand_addr(), -1);
                    end
                    3: op_mem(1'b0, 4'hF, rand_addr(), $urandom, 1'b0, 32'h0);
                    4: op_mem(1'b1, 4'($urandom_range(1, 15)), rand_addr(), $urandom, 1'b0, 32'h0);
                    default: op_mem(1'($urandom_range(0, 1)), 4'hF, rand_addr(), $urandom,
                                    1'b1, rand_addr());
                endcase
            end
            op_idle(3);
            chk("txn_drained", 32'(txn_q.size()), 32'h0);
            chk("stall_drained", 32'(stall_q.size()), 32'h0);
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && n_done < 3; i++)
            @(posedge clk);
        check("all_lanes_finished", 32'(n_done), 32'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data RAM between the fetch stage and the MEM stage, sequences each multi-cycle RAM access, and drives the 6-bit pipeline stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It sits beside the pipeline control logic. Its stall output is OR-ed with the other stall requests before distribution. Fetch results go to if_id as `if_inst`; load results return to the MEM stage.

## Interface
Parameters:
- `MEM_LAT`, default 2: RAM access length in cycles (legal 1..7); ram_rdata is valid in the last cycle of an access.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, held while stalled.
- `if_addr` in 32: fetch address, stable while `if_req` is high.
- `if_inst` out 32: registered fetch data.
- `mem_req` in 1: MEM-stage access request.
- `mem_we` in 1: write request.
- `mem_sel` in 4: byte enables.
- `mem_addr` in 32: data address.
- `mem_wdata` in 32: store data.
- `mem_rdata` out 32: registered load data.
- `flush` in 1: exception/branch flush pulse.
- `stall` out 6: stall vector. Bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb. A 1 means Stop.
- `ram_ce`, `ram_we` out 1: RAM enable and write enable, registered.
- `ram_sel` out 4: RAM byte enables, registered.
- `ram_addr`, `ram_wdata` out 32: RAM address and write data, registered.
- `ram_rdata` in 32: RAM read data.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM.
- IDLE:
  - `mem_req` has priority; the MEM instruction is older. Grant goes to BUSY_MEM.
  - Else `if_req` grants to BUSY_IF.
  - Else stay in IDLE.
- On grant, `ram_*` are loaded from the granted request. Fetch drives `ram_we=0`, `ram_sel=4'hF`. The 3-bit counter `cnt` is cleared.
- BUSY_x:
  - `ram_ce=1` with all RAM outputs held constant.
  - `cnt` increments each cycle.
  - When `cnt==MEM_LAT-1`, `ram_rdata` is captured: into `if_inst` for BUSY_IF, or into `mem_rdata` for a BUSY_MEM read.
  - On that same edge, `ram_ce`/`ram_we` clear and the state moves to DONE_x.
  - A write does not update `mem_rdata`.
- DONE_x: the requester's stall is released for exactly one cycle, so the pipeline consumes the data. Next state is IDLE unconditionally; a still-high request is treated as already satisfied.
- Stall vector:
  - BUSY_MEM, or an IDLE cycle granting MEM: `6'b011111`.
  - BUSY_IF, or an IDLE cycle granting IF: `6'b000011`.
  - DONE_MEM with `if_req` high: `6'b000011`. This inserts a bubble into ID.
  - DONE_IF, IDLE with no grant, and reset: `6'b000000`.
- Flush:
  - In BUSY_IF, or in an IDLE cycle granting IF, flush sets `kill`. Stall is forced to `0` in the flush cycle so pc loads the new target.
  - The RAM access still runs to completion, with stall `000011` in the remaining busy cycles.
  - At completion, `if_inst` is not updated; the state goes to IDLE, skipping DONE_IF; `kill` clears.
  - Flush in BUSY_MEM/DONE_MEM has no effect.
  - Flush in DONE_IF and IDLE with no grant has no effect.
- Reset, including mid-access:
  - state→IDLE.
  - `cnt`, `kill`, all `ram_*`, `if_inst`, `mem_rdata` → 0.
  - `stall` reads 0 in the reset cycle and the cycle after.
  - An interrupted write may be partial; no retry.

## Timing
- Grant in cycle t. `ram_ce` is high in cycles t+1..t+MEM_LAT. Data is captured at the end of t+MEM_LAT. DONE occupies t+MEM_LAT+1, with data valid on `if_inst`/`mem_rdata` from that cycle.
- Cost per access: MEM_LAT+2 cycles. Stall is asserted in t..t+MEM_LAT.
- Outputs `if_inst`/`mem_rdata` hold their value until the next capture of the same kind.
- `stall` is combinational from state, `if_req`, `mem_req`, `flush`. All other outputs are registered.
- Simultaneous `if_req` and `mem_req` in IDLE: MEM first. IF is granted in the IDLE following DONE_MEM, with no starvation of MEM.
- MEM_LAT=1: BUSY lasts one cycle. Capture happens on the first busy edge.

## Test plan
- **Fetch, MEM_LAT=2, `if_addr=0x100`, RAM returns `0x24080005`:** `ram_ce` high in 2 cycles; stall=`000011` for 3 cycles, then DONE with stall=0 and `if_inst=0x24080005`; next fetch granted 1 cycle later.
- **`if_req` and `mem_req` (read `0x200`→`0xDEADBEEF`) asserted together:** MEM granted; stall=`011111` for 3 cycles; DONE_MEM stall=`000011` with `mem_rdata=0xDEADBEEF`; IF granted the following IDLE cycle.
- **Store `mem_we=1`, `mem_sel=4'b0011`, `wdata=0x1234`, `addr=0x40`:** `ram_we=1`, `ram_sel=3` for 2 cycles; `mem_rdata` unchanged.
- **Flush in the second cycle of a fetch:** stall=0 in the flush cycle; the access finishes; `if_inst` keeps its old value; no DONE_IF; a new fetch is granted 1 cycle after completion.
- **`rst` asserted during BUSY_MEM (MEM_LAT=4, cnt=2):** next cycle state IDLE, `ram_ce=0`, `stall=0`, `if_inst=mem_rdata=0`.
- **MEM_LAT=1 back-to-back fetches:** each fetch takes 3 cycles, `ram_ce` pulses 1 cycle, and data is correct on every DONE.
